// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expansion: one round key per clock, full 11-key schedule held
// until the next accepted start. aes_sbox is the byte substitution used by SubWord.

module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [2047:0] SBoxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  assign data_o = SBoxTable[(11'd2040 - {data_i, 3'b000}) +: 8];

endmodule

module aes_key_expander #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [KEY_W-1:0]          i_Key,
  input  logic                      i_fStart,
  output logic [(NR+1)*KEY_W-1:0]   o_KeySchedule,
  output logic                      o_fBusy,
  output logic                      o_fValid,
  output logic                      o_fDone
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExpand = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [3:0] LastRound = 4'(NR);

  logic [1:0]       state_q, state_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] rk_q [NR+1];

  logic             start_ok;
  logic [3:0]       prev_idx;
  logic [KEY_W-1:0] prev_rk, next_rk;
  logic [31:0]      rot_word, sub_word, t_word;
  logic [31:0]      n0, n1, n2, n3;
  logic [7:0]       rcon;

  assign start_ok = i_fStart && ((state_q == StIdle) || (state_q == StDone));

  // Guard keeps the read index in range while idle (rcnt_q == 0).
  assign prev_idx = (rcnt_q == 4'd0) ? 4'd0 : rcnt_q - 4'd1;
  assign prev_rk  = rk_q[prev_idx];

  always_comb begin
    rcon = 8'h00;
    case (rcnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_word[8*i +: 8]),
      .data_o (sub_word[8*i +: 8])
    );
  end

  assign t_word  = sub_word ^ {rcon, 24'h000000};
  assign n0      = prev_rk[127:96] ^ t_word;
  assign n1      = n0 ^ prev_rk[95:64];
  assign n2      = n1 ^ prev_rk[63:32];
  assign n3      = n2 ^ prev_rk[31:0];
  assign next_rk = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (i_fStart) begin
          state_d = StExpand;
          rcnt_d  = 4'd1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      StExpand: begin
        rcnt_d = rcnt_q + 4'd1;
        if (rcnt_q == LastRound) begin
          state_d = StDone;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      rcnt_q  <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (start_ok) begin
        rk_q[0] <= i_Key;
      end else if (state_q == StExpand) begin
        rk_q[rcnt_q] <= next_rk;
      end
    end
  end

  // RK0 occupies the most significant slice of the schedule.
  always_comb begin
    o_KeySchedule = '0;
    for (int i = 0; i <= NR; i++) begin
      o_KeySchedule[KEY_W*(NR-i) +: KEY_W] = rk_q[i];
    end
  end

  assign o_fBusy  = busy_q;
  assign o_fValid = valid_q;
  assign o_fDone  = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 vectors plus random keys against a word-level
// key-schedule model whose S-box is derived from GF(2^8) inversion and the affine map.

module tb_aes_key_expander;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key;
  logic [1407:0] sched;
  logic          busy, valid, done;

  int errs   = 0;
  int checks = 0;

  logic [7:0] ref_sbox [256];

  localparam logic [127:0] KeyA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyB  = 128'h5468617473206d79204b756e67204675;

  aes_key_expander u_dut (
    .Clk           (clk),
    .Rst           (rst),
    .i_Key         (key),
    .i_fStart      (start),
    .o_KeySchedule (sched),
    .o_fBusy       (busy),
    .o_fValid      (valid),
    .o_fDone       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] s, input int r);
    return s[1407-128*r -: 128];
  endfunction

  function automatic logic [1407:0] expand_ref(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1407:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox[tmp[31:24]], ref_sbox[tmp[23:16]], ref_sbox[tmp[15:8]],
               ref_sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = '0;
    for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
    return s;
  endfunction

  task automatic check_sched(input string tag, input logic [127:0] k);
    logic [1407:0] exp;
    exp = expand_ref(k);
    for (int r = 0; r <= 10; r++) begin
      check_eq($sformatf("%s_rk%0d", tag, r), rk_of(sched, r), rk_of(exp, r));
    end
  endtask

  // Pulses start with key k; optionally re-requests start with k2 at edge restart_at
  // and/or scrambles i_Key every cycle. Checks latency, the done pulse and final flags.
  task automatic run_expand(input string tag, input logic [127:0] k, input int restart_at,
                            input logic [127:0] k2, input bit jitter);
    int lat;
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_e0_busy"}, 128'(busy), 128'd1);
    check_eq({tag, "_e0_valid"}, 128'(valid), 128'd0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      start = (c == restart_at);
      if (c == restart_at) key = k2;
      else if (jitter) key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      if (done) lat = c;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 128'(lat), 128'd10);
    check_eq({tag, "_valid"}, 128'(valid), 128'd1);
    check_eq({tag, "_busy"}, 128'(busy), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 128'(done), 128'd0);
    check_sched(tag, k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_seen;
    logic [127:0] rk;
    logic [7:0] inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                    ^ 8'h63;
    end

    // T1: reset held with start asserted
    rst   = 1'b1;
    start = 1'b1;
    key   = KeyA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_valid", 128'(valid), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_sched", 128'(|sched), 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_busy", 128'(busy), 128'd0);

    // T2: FIPS-197 A.1
    run_expand("fips", KeyA, 0, '0, 1'b0);
    check_eq("fips_rk1_const", rk_of(sched, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("fips_rk10_const", rk_of(sched, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // T3: second known vector
    run_expand("kb", KeyB, 0, '0, 1'b0);
    check_eq("kb_rk1_const", rk_of(sched, 1), 128'he232fcf191129188b159e4e6d679a293);
    check_eq("kb_rk10_const", rk_of(sched, 10), 128'h28fddef86da4244accc0a4fe3b316f26);

    // T4: start during expansion is ignored, then restart from DONE
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_expand("busy", rk, 4, KeyB, 1'b0);
    run_expand("restart", KeyA, 0, '0, 1'b0);

    // T5: reset at E5 aborts
    @(negedge clk);
    key   = KeyB;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 128'(busy), 128'd0);
    check_eq("abort_valid", 128'(valid), 128'd0);
    check_eq("abort_done", 128'(done), 128'd0);
    check_eq("abort_sched", 128'(|sched), 128'd0);
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done || valid || busy) done_seen++;
    end
    check_eq("abort_quiet", 128'(done_seen), 128'd0);
    run_expand("post_abort", KeyB, 0, '0, 1'b0);

    // T6: key scrambled every cycle after E0
    run_expand("jitter", {$urandom, $urandom, $urandom, $urandom}, 0, '0, 1'b1);

    // Random keys, some with an ignored mid-expansion start
    for (int n = 0; n < 12; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_expand($sformatf("rnd%0d", n), rk, (n % 3 == 0) ? int'($urandom_range(1, 9)) : 0,
                 {$urandom, $urandom, $urandom, $urandom}, n[0]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
